// File: rtl/decoder_checker.sv
// -----------------------------------------------------------------------------
// decoder_checker
//
// Purpose:
//   Sink-side sequence checker for the decoder path. It consumes an AXI-Stream
//   of beats that carry an incrementing 32-bit value, replicated in every
//   32-bit lane. It locks onto that sequence and keeps saturating statistics.
//
// Parameters:
//   DWIDTH     - stream width, a multiple of 32 (DWIDTH/32 lanes)
//   LOCK_CNT   - consecutive in-sequence beats needed to lock (>= 2)
//   UNLOCK_CNT - consecutive mismatching beats that drop lock (>= 1)
//   CWIDTH     - width of each statistics counter
//
// Ports:
//   s_axis_aclk   in   clock
//   s_axis_rst    in   synchronous active-high reset
//   s_axis_tdata  in   beat data, lane 0 = s_axis_tdata[31:0]
//   s_axis_tvalid in   beat valid
//   s_axis_tready out  sink ready (1 whenever reset is low)
//   clear_stats   in   single-cycle pulse, zeroes all statistics counters
//   locked        out  checker FSM is in LOCKED (registered)
//   beat_cnt      out  accepted beats (saturating)
//   err_cnt       out  mismatching beats while LOCKED (saturating)
//   lock_loss_cnt out  LOCKED->SEARCH transitions (saturating)
//
// Handshake: a beat transfers on a clock edge where s_axis_tvalid and
// s_axis_tready are both 1. tready depends only on reset, so the checker never
// back-pressures and sustains one beat per cycle.
//
// Pipeline: stage 1 registers the accepted beat, stage 2 compares it and
// updates the FSM and counters, so effects appear two cycles after acceptance.
// -----------------------------------------------------------------------------
module decoder_checker #(
  parameter int DWIDTH     = 64,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 4,
  parameter int CWIDTH     = 32
) (
  input  logic              s_axis_aclk,
  input  logic              s_axis_rst,
  input  logic [DWIDTH-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              clear_stats,
  output logic              locked,
  output logic [CWIDTH-1:0] beat_cnt,
  output logic [CWIDTH-1:0] err_cnt,
  output logic [CWIDTH-1:0] lock_loss_cnt
);

  localparam int LANES = DWIDTH / 32;
  localparam int GW    = $clog2(LOCK_CNT + 1);
  localparam int BW    = $clog2(UNLOCK_CNT + 1);

  localparam logic [GW-1:0]     G_ONE    = GW'(1);
  localparam logic [GW-1:0]     G_LOCK   = GW'(LOCK_CNT);
  localparam logic [BW-1:0]     B_ONE    = BW'(1);
  localparam logic [BW-1:0]     B_UNLOCK = BW'(UNLOCK_CNT);
  localparam logic [CWIDTH-1:0] C_ONE    = CWIDTH'(1);

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Stage 1
  logic              r_s1_valid;
  logic [DWIDTH-1:0] r_s1_data;

  // Stage 2 state
  state_t            r_state;
  logic              r_locked;
  logic [31:0]       r_expected;
  logic [GW-1:0]     r_good_run;
  logic [BW-1:0]     r_bad_run;
  logic [CWIDTH-1:0] r_beat_cnt;
  logic [CWIDTH-1:0] r_err_cnt;
  logic [CWIDTH-1:0] r_loss_cnt;

  logic              w_accept;
  logic [31:0]       w_lane0;
  logic              w_lanes_eq;
  logic              w_match;
  logic [GW-1:0]     w_good_next;
  logic [BW-1:0]     w_bad_next;
  logic              w_do_lock;
  logic              w_err;
  logic              w_lose;

  assign s_axis_tready = ~s_axis_rst;
  assign w_accept      = s_axis_tvalid && s_axis_tready;

  // ---------------------------------------------------------------------------
  // Stage 1: capture the accepted beat
  // ---------------------------------------------------------------------------
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_data <= s_axis_tdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 compare logic
  // ---------------------------------------------------------------------------
  assign w_lane0 = r_s1_data[31:0];

  always_comb begin
    w_lanes_eq = 1'b1;
    for (int i = 1; i < LANES; i++) begin
      if (r_s1_data[i*32 +: 32] != w_lane0) begin
        w_lanes_eq = 1'b0;
      end
    end
  end

  assign w_match = w_lanes_eq && (w_lane0 == r_expected);

  // In SEARCH a consistent beat that is off-sequence still starts a new run of
  // one, because expected is resynchronised to it.
  assign w_good_next = w_match ? (r_good_run + G_ONE) : (w_lanes_eq ? G_ONE : '0);
  assign w_bad_next  = r_bad_run + B_ONE;

  assign w_do_lock = r_s1_valid && (r_state == ST_SEARCH) && (w_good_next == G_LOCK);
  assign w_err     = r_s1_valid && (r_state == ST_LOCKED) && !w_match;
  assign w_lose    = w_err && (w_bad_next == B_UNLOCK);

  // ---------------------------------------------------------------------------
  // Lock FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_rst) begin
      r_state    <= ST_SEARCH;
      r_locked   <= 1'b0;
      r_expected <= '0;
      r_good_run <= '0;
      r_bad_run  <= '0;
    end else if (r_s1_valid) begin
      case (r_state)
        ST_SEARCH: begin
          r_expected <= w_lane0 + 32'd1;
          if (w_do_lock) begin
            r_state    <= ST_LOCKED;
            r_locked   <= 1'b1;
            r_good_run <= '0;
            r_bad_run  <= '0;
          end else begin
            r_good_run <= w_good_next;
          end
        end
        ST_LOCKED: begin
          // Free-running: once locked the data never reseeds expected.
          r_expected <= r_expected + 32'd1;
          if (w_match) begin
            r_bad_run <= '0;
          end else if (w_lose) begin
            r_state    <= ST_SEARCH;
            r_locked   <= 1'b0;
            r_good_run <= '0;
            r_bad_run  <= '0;
          end else begin
            r_bad_run <= w_bad_next;
          end
        end
        default: begin
          r_state  <= ST_SEARCH;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating statistics; clear_stats overrides any same-cycle increment.
  // ---------------------------------------------------------------------------
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_rst || clear_stats) begin
      r_beat_cnt <= '0;
      r_err_cnt  <= '0;
      r_loss_cnt <= '0;
    end else begin
      if (r_s1_valid && !(&r_beat_cnt)) begin
        r_beat_cnt <= r_beat_cnt + C_ONE;
      end
      if (w_err && !(&r_err_cnt)) begin
        r_err_cnt <= r_err_cnt + C_ONE;
      end
      if (w_lose && !(&r_loss_cnt)) begin
        r_loss_cnt <= r_loss_cnt + C_ONE;
      end
    end
  end

  assign locked        = r_locked;
  assign beat_cnt      = r_beat_cnt;
  assign err_cnt       = r_err_cnt;
  assign lock_loss_cnt = r_loss_cnt;

endmodule

// File: tb/tb_decoder_checker.sv
// -----------------------------------------------------------------------------
// tb_decoder_checker
//
// Bench for decoder_checker (DWIDTH=64, LOCK_CNT=4, UNLOCK_CNT=4). A table of
// beats with hand-derived expected outputs is driven one entry per cycle; each
// entry's expectation is queued with the cycle it is due (two cycles later)
// and compared when that cycle arrives. Note an entry's expectation includes
// the clear_stats of the following entry, because that pulse is sampled on the
// same edge that lands the entry's increment. Reset abort, relock and counter
// saturation (second instance with CWIDTH=4) are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_decoder_checker;

  localparam int DW = 64;
  localparam int CW = 32;
  localparam int EW = 1 + 3 * CW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          clear;

  logic          tready;
  logic          locked;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] err_cnt;
  logic [CW-1:0] loss_cnt;

  logic          sat_tready;
  logic          sat_locked;
  logic [3:0]    sat_beat;
  logic [3:0]    sat_err;
  logic [3:0]    sat_loss;

  decoder_checker #(.DWIDTH(DW), .LOCK_CNT(4), .UNLOCK_CNT(4), .CWIDTH(CW)) dut (
    .s_axis_aclk   (clk),
    .s_axis_rst    (rst),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .clear_stats   (clear),
    .locked        (locked),
    .beat_cnt      (beat_cnt),
    .err_cnt       (err_cnt),
    .lock_loss_cnt (loss_cnt)
  );

  decoder_checker #(.DWIDTH(DW), .LOCK_CNT(4), .UNLOCK_CNT(4), .CWIDTH(4)) dut_sat (
    .s_axis_aclk   (clk),
    .s_axis_rst    (rst),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (sat_tready),
    .clear_stats   (clear),
    .locked        (sat_locked),
    .beat_cnt      (sat_beat),
    .err_cnt       (sat_err),
    .lock_loss_cnt (sat_loss)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0]   l0;
    logic [31:0]   l1;
    logic          v;
    logic          clr;
    logic          el;
    logic [CW-1:0] eb;
    logic [CW-1:0] ee;
    logic [CW-1:0] ex;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [31:0] l0, input logic [31:0] l1, input logic v,
                     input logic clr, input logic el, input int eb, input int ee,
                     input int ex);
    vec_t t;
    t.l0  = l0;
    t.l1  = l1;
    t.v   = v;
    t.clr = clr;
    t.el  = el;
    t.eb  = CW'(eb);
    t.ee  = CW'(ee);
    t.ex  = CW'(ex);
    tbl.push_back(t);
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int            due_q[$];
  int            vec_q[$];
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  logic [EW-1:0] mon_e;
  int            mon_n;
  always @(negedge clk) begin
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      mon_e = exp_q.pop_front();
      mon_n = vec_q.pop_front();
      void'(due_q.pop_front());
      check($sformatf("vec%0d locked", mon_n), 64'(locked), 64'(mon_e[EW-1]));
      check($sformatf("vec%0d beat_cnt", mon_n), 64'(beat_cnt), 64'(mon_e[3*CW-1:2*CW]));
      check($sformatf("vec%0d err_cnt", mon_n), 64'(err_cnt), 64'(mon_e[2*CW-1:CW]));
      check($sformatf("vec%0d lock_loss_cnt", mon_n), 64'(loss_cnt), 64'(mon_e[CW-1:0]));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver ----------------
  task automatic beat(input logic [31:0] v);
    @(posedge clk);
    #1;
    tdata  = {v, v};
    tvalid = 1'b1;
  endtask

  initial begin
    rst    = 1'b1;
    tvalid = 1'b0;
    clear  = 1'b0;
    tdata  = '0;

    // Lock near the wrap point, then cross it.
    add(32'hFFFF_FFFA, 32'hFFFF_FFFA, 1, 0, 0,  1, 0, 0);
    add(32'hFFFF_FFFB, 32'hFFFF_FFFB, 1, 0, 0,  2, 0, 0);
    add(32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0,  3, 0, 0);
    add(32'hFFFF_FFFD, 32'hFFFF_FFFD, 1, 0, 1,  4, 0, 0);
    add(32'hFFFF_FFFE, 32'hFFFF_FFFE, 1, 0, 1,  5, 0, 0);
    add(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 1,  6, 0, 0);
    add(32'h0000_0000, 32'h0000_0000, 1, 0, 1,  7, 0, 0);
    add(32'h0000_0001, 32'h0000_0001, 1, 0, 1,  8, 0, 0);
    // Three isolated lane-1 corruptions.
    add(32'h0000_0002, 32'h0BAD_0000, 1, 0, 1,  9, 1, 0);
    add(32'h0000_0003, 32'h0000_0003, 1, 0, 1, 10, 1, 0);
    add(32'h0000_0004, 32'h0BAD_0000, 1, 0, 1, 11, 2, 0);
    add(32'h0000_0005, 32'h0000_0005, 1, 0, 1, 12, 2, 0);
    add(32'h0000_0006, 32'h0BAD_0000, 1, 0, 1, 13, 3, 0);
    add(32'h0000_0007, 32'h0000_0007, 1, 0, 1, 14, 3, 0);
    // Idle cycle with garbage data.
    add(32'hDEAD_BEEF, 32'h1234_5678, 0, 0, 1, 14, 3, 0);
    // Four beats at expected+10 drop lock.
    add(32'd18, 32'd18, 1, 0, 1, 15, 4, 0);
    add(32'd19, 32'd19, 1, 0, 1, 16, 5, 0);
    add(32'd20, 32'd20, 1, 0, 1, 17, 6, 0);
    add(32'd21, 32'd21, 1, 0, 0, 18, 7, 1);
    // Relock on the continuing data.
    add(32'd22, 32'd22, 1, 0, 0, 19, 7, 1);
    add(32'd23, 32'd23, 1, 0, 0, 20, 7, 1);
    add(32'd24, 32'd24, 1, 0, 0, 21, 7, 1);
    add(32'd25, 32'd25, 1, 0, 1, 22, 7, 1);
    // Beat 26's increment lands on the same edge as the next entry's clear.
    add(32'd26, 32'd26, 1, 0, 1,  0, 0, 0);
    add(32'd0,  32'd0,  0, 1, 1,  0, 0, 0);
    add(32'd27, 32'd27, 1, 0, 1,  1, 0, 0);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst tready", 64'(tready), 64'd0);
    check("rst locked", 64'(locked), 64'd0);
    check("rst beat_cnt", 64'(beat_cnt), 64'd0);
    check("rst err_cnt", 64'(err_cnt), 64'd0);
    check("rst lock_loss_cnt", 64'(loss_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("run tready", 64'(tready), 64'd1);

    // Table.
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      tdata  = {tbl[i].l1, tbl[i].l0};
      tvalid = tbl[i].v;
      clear  = tbl[i].clr;
      exp_q.push_back({tbl[i].el, tbl[i].eb, tbl[i].ee, tbl[i].ex});
      due_q.push_back(cyc + 2);
      vec_q.push_back(i);
    end
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    clear  = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    // Mid-stream reset while locked: beat 28 is in the pipeline when reset hits.
    beat(32'd28);
    @(posedge clk);
    #1;
    rst   = 1'b1;
    tdata = {32'd29, 32'd29};
    @(negedge clk);
    check("midrst tready", 64'(tready), 64'd0);
    @(posedge clk);
    #1;
    tdata = {32'd30, 32'd30};
    @(negedge clk);
    check("midrst tready2", 64'(tready), 64'd0);
    check("midrst locked", 64'(locked), 64'd0);
    check("midrst beat_cnt", 64'(beat_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    tdata = {32'd100, 32'd100};
    for (int k = 1; k < 4; k++) beat(32'd100 + 32'(k));
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    @(negedge clk);
    check("relock after 3 locked", 64'(locked), 64'd0);
    check("relock after 3 beat_cnt", 64'(beat_cnt), 64'd3);
    @(negedge clk);
    check("relock after 4 locked", 64'(locked), 64'd1);
    check("relock after 4 beat_cnt", 64'(beat_cnt), 64'd4);
    check("relock err_cnt", 64'(err_cnt), 64'd0);
    check("relock lock_loss_cnt", 64'(loss_cnt), 64'd0);

    // Sustained back-to-back beats; the 4-bit instance saturates.
    for (int k = 0; k < 20; k++) beat(32'd104 + 32'(k));
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("burst beat_cnt", 64'(beat_cnt), 64'd24);
    check("burst err_cnt", 64'(err_cnt), 64'd0);
    check("burst locked", 64'(locked), 64'd1);
    check("sat beat_cnt", 64'(sat_beat), 64'd15);
    check("sat locked", 64'(sat_locked), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
